// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared pipeline widths, opcodes, forwarding encodings, ID/EX control struct and WB bypass helper
package id_ex_stage_pkg;
  localparam int DATA_W = 16;
  localparam int REG_W = 4;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_LOAD = 4'd3;
  localparam logic [3:0] OP_STORE = 4'd4;
  localparam logic [2:0] FWD_NONE = 3'd0;
  localparam logic [2:0] FWD_MEM1 = 3'd1;
  localparam logic [2:0] FWD_MEM2 = 3'd2;
  localparam logic [2:0] FWD_WB1 = 3'd3;
  localparam logic [2:0] FWD_WB2 = 3'd4;
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic write_op2;
    logic mem_read;
    logic mem_write;
  } ctrl_t;
  function automatic logic [DATA_W-1:0] wb_bypass(
    input logic [REG_W-1:0] rs,
    input logic [DATA_W-1:0] rf,
    input logic wr,
    input logic wo2,
    input logic [REG_W-1:0] rd1,
    input logic [REG_W-1:0] rd2,
    input logic [DATA_W-1:0] d1,
    input logic [DATA_W-1:0] d2
  );
    return (wr & wo2 & rd2 == rs) ? d2 : (wr & rd1 == rs) ? d1 : rf;
  endfunction
endpackage

// File: rtl/id_ex_stage_fwd_select.sv
// fwd_select: priority forwarding matcher for one ALU operand (rs, use_rs, EX/MEM producer fields in; sel out)
module fwd_select
  import id_ex_stage_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic             use_rs,
  input  logic             ex_valid,
  input  logic             ex_reg_write,
  input  logic             ex_write_op2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd1,
  input  logic [REG_W-1:0] ex_rd2,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic             mem_write_op2,
  input  logic [REG_W-1:0] mem_rd1,
  input  logic [REG_W-1:0] mem_rd2,
  output logic [2:0]       sel
);
  always_comb begin
    sel = !use_rs ? FWD_NONE :
          (ex_valid & ex_reg_write & ex_write_op2 & ex_rd2 == rs) ? FWD_MEM2 :
          (ex_valid & ex_reg_write & ex_rd1 == rs & ~ex_mem_read) ? FWD_MEM1 :
          (mem_valid & mem_reg_write & mem_write_op2 & mem_rd2 == rs) ? FWD_WB2 :
          (mem_valid & mem_reg_write & mem_rd1 == rs) ? FWD_WB1 : FWD_NONE;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, bubble/flush, WB bypass and registered forwarding selects (clk/rst, id_*/rf_*/wb_*/flush in; stall, ex_*, fwd_a/fwd_b out)
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [3:0]        id_op,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [REG_W-1:0]  id_rd1,
  input  logic [REG_W-1:0]  id_rd2,
  input  logic              id_reg_write,
  input  logic              id_write_op2,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic [REG_W-1:0]  wb_rd1,
  input  logic [REG_W-1:0]  wb_rd2,
  input  logic              wb_reg_write,
  input  logic              wb_write_op2,
  input  logic [DATA_W-1:0] wb_data1,
  input  logic [DATA_W-1:0] wb_data2,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [3:0]        ex_op,
  output logic [REG_W-1:0]  ex_rs1,
  output logic [REG_W-1:0]  ex_rs2,
  output logic [REG_W-1:0]  ex_rd1,
  output logic [REG_W-1:0]  ex_rd2,
  output logic              ex_reg_write,
  output logic              ex_write_op2,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [2:0]        fwd_a,
  output logic [2:0]        fwd_b
);
  ctrl_t ex_c;
  logic bubble;
  logic mem_valid, mem_reg_write, mem_write_op2;
  logic [REG_W-1:0] mem_rd1, mem_rd2;
  logic [2:0] fa, fb;
  assign {ex_valid, ex_reg_write, ex_write_op2, ex_mem_read, ex_mem_write} = ex_c;
  assign stall = id_valid & ~flush & ex_c.valid & ex_c.mem_read & ex_c.reg_write &
                 ((id_use_rs1 & id_rs1 == ex_rd1) | (id_use_rs2 & id_rs2 == ex_rd1));
  assign bubble = flush | stall | ~id_valid;
  fwd_select u_fwd_a (
    .rs(id_rs1), .use_rs(id_use_rs1),
    .ex_valid(ex_c.valid), .ex_reg_write(ex_c.reg_write), .ex_write_op2(ex_c.write_op2),
    .ex_mem_read(ex_c.mem_read), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_write_op2(mem_write_op2),
    .mem_rd1(mem_rd1), .mem_rd2(mem_rd2), .sel(fa)
  );
  fwd_select u_fwd_b (
    .rs(id_rs2), .use_rs(id_use_rs2),
    .ex_valid(ex_c.valid), .ex_reg_write(ex_c.reg_write), .ex_write_op2(ex_c.write_op2),
    .ex_mem_read(ex_c.mem_read), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_write_op2(mem_write_op2),
    .mem_rd1(mem_rd1), .mem_rd2(mem_rd2), .sel(fb)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_c <= '0;
      ex_op <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      ex_rd1 <= '0;
      ex_rd2 <= '0;
      ex_imm <= '0;
      ex_a <= '0;
      ex_b <= '0;
      fwd_a <= FWD_NONE;
      fwd_b <= FWD_NONE;
      mem_valid <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_write_op2 <= 1'b0;
      mem_rd1 <= '0;
      mem_rd2 <= '0;
    end else begin
      ex_c <= bubble ? ctrl_t'('0) : ctrl_t'{valid: 1'b1, reg_write: id_reg_write,
              write_op2: id_write_op2 & id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write};
      ex_op <= id_op;
      ex_rs1 <= id_rs1;
      ex_rs2 <= id_rs2;
      ex_rd1 <= id_rd1;
      ex_rd2 <= id_rd2;
      ex_imm <= id_imm;
      ex_a <= wb_bypass(id_rs1, rf_data1, wb_reg_write, wb_write_op2, wb_rd1, wb_rd2, wb_data1, wb_data2);
      ex_b <= wb_bypass(id_rs2, rf_data2, wb_reg_write, wb_write_op2, wb_rd1, wb_rd2, wb_data1, wb_data2);
      fwd_a <= bubble ? FWD_NONE : fa;
      fwd_b <= bubble ? FWD_NONE : fb;
      mem_valid <= ex_c.valid;
      mem_reg_write <= ex_c.reg_write;
      mem_write_op2 <= ex_c.write_op2;
      mem_rd1 <= ex_rd1;
      mem_rd2 <= ex_rd2;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;
  logic clk = 1'b0, rst;
  logic id_valid, id_use_rs1, id_use_rs2;
  logic [3:0] id_op;
  logic [REG_W-1:0] id_rs1, id_rs2, id_rd1, id_rd2;
  logic id_reg_write, id_write_op2, id_mem_read, id_mem_write;
  logic [DATA_W-1:0] id_imm, rf_data1, rf_data2;
  logic [REG_W-1:0] wb_rd1, wb_rd2;
  logic wb_reg_write, wb_write_op2;
  logic [DATA_W-1:0] wb_data1, wb_data2;
  logic flush, stall, ex_valid;
  logic [3:0] ex_op;
  logic [REG_W-1:0] ex_rs1, ex_rs2, ex_rd1, ex_rd2;
  logic ex_reg_write, ex_write_op2, ex_mem_read, ex_mem_write;
  logic [DATA_W-1:0] ex_imm, ex_a, ex_b;
  logic [2:0] fwd_a, fwd_b;
  int n_cmp = 0, n_bad = 0;
  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_op(id_op), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_reg_write(id_reg_write), .id_write_op2(id_write_op2), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_imm(id_imm), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_rd1(wb_rd1), .wb_rd2(wb_rd2), .wb_reg_write(wb_reg_write), .wb_write_op2(wb_write_op2),
    .wb_data1(wb_data1), .wb_data2(wb_data2), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .ex_reg_write(ex_reg_write), .ex_write_op2(ex_write_op2),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_imm(ex_imm),
    .ex_a(ex_a), .ex_b(ex_b), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic instr(input logic [3:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd1, input logic [3:0] rd2, input logic u1, input logic u2,
                       input logic rw, input logic wo2, input logic mr, input logic mw);
    id_valid = 1'b1;
    id_op = op;
    id_rs1 = rs1;
    id_rs2 = rs2;
    id_rd1 = rd1;
    id_rd2 = rd2;
    id_use_rs1 = u1;
    id_use_rs2 = u2;
    id_reg_write = rw;
    id_write_op2 = wo2;
    id_mem_read = mr;
    id_mem_write = mw;
  endtask
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    id_valid = 1'b0;
    instr(OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    id_valid = 1'b0;
    id_imm = '0;
    rf_data1 = '0;
    rf_data2 = '0;
    wb_rd1 = '0;
    wb_rd2 = '0;
    wb_reg_write = 1'b0;
    wb_write_op2 = 1'b0;
    wb_data1 = '0;
    wb_data2 = '0;
    tick;
    tick;
    check("rst_valid", ex_valid, 0);
    check("rst_fwd_a", fwd_a, 0);
    check("rst_ex_a", ex_a, 0);
    check("rst_stall", stall, 0);
    rst = 1'b0;
    instr(OP_ADD, 0, 1, 2, 0, 1, 1, 1, 0, 0, 0);
    rf_data1 = 16'h0001;
    rf_data2 = 16'h0001;
    #1 check("add_stall", stall, 0);
    tick;
    check("add_valid", ex_valid, 1);
    check("add_a", ex_a, 16'h0001);
    check("add_b", ex_b, 16'h0001);
    check("add_fwd_a", fwd_a, 0);
    check("add_fwd_b", fwd_b, 0);
    instr(OP_LOAD, 0, 0, 3, 0, 1, 0, 1, 0, 1, 0);
    id_imm = 16'h0004;
    #1 check("ld_stall", stall, 0);
    tick;
    check("ld_mem_read", ex_mem_read, 1);
    check("ld_imm", ex_imm, 16'h0004);
    check("ld_op", ex_op, OP_LOAD);
    instr(OP_ADD, 3, 2, 4, 0, 1, 1, 1, 0, 0, 0);
    #1 check("lu_stall", stall, 1);
    tick;
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_rw", ex_reg_write, 0);
    check("lu_bubble_fwd_a", fwd_a, 0);
    #1 check("lu_stall_clear", stall, 0);
    tick;
    check("lu_valid", ex_valid, 1);
    check("lu_fwd_a", fwd_a, 3);
    check("lu_fwd_b", fwd_b, 0);
    instr(OP_ADD, 1, 1, 5, 0, 1, 1, 1, 0, 0, 0);
    tick;
    check("add5_fwd_a", fwd_a, 0);
    instr(OP_SUB, 5, 5, 6, 0, 1, 1, 1, 0, 0, 0);
    #1 check("sub_stall", stall, 0);
    tick;
    check("sub_fwd_a", fwd_a, 1);
    check("sub_fwd_b", fwd_b, 1);
    instr(OP_MUL, 1, 1, 7, 8, 1, 1, 1, 1, 0, 0);
    tick;
    check("mul_wo2", ex_write_op2, 1);
    check("mul_rd2", ex_rd2, 8);
    instr(OP_ADD, 8, 7, 9, 0, 1, 1, 1, 0, 0, 0);
    tick;
    check("add9_fwd_a", fwd_a, 2);
    check("add9_fwd_b", fwd_b, 1);
    instr(OP_ADD, 8, 7, 10, 0, 1, 1, 1, 0, 0, 0);
    tick;
    check("add10_fwd_a", fwd_a, 4);
    check("add10_fwd_b", fwd_b, 3);
    instr(OP_MUL, 1, 1, 8, 8, 1, 1, 1, 1, 0, 0);
    tick;
    check("mul88_fwd_a", fwd_a, 0);
    instr(OP_ADD, 8, 8, 11, 0, 1, 0, 1, 0, 0, 0);
    tick;
    check("same_rd_fwd_a", fwd_a, 2);
    check("unused_rs2_fwd_b", fwd_b, 0);
    instr(OP_ADD, 1, 2, 12, 0, 1, 1, 1, 0, 0, 0);
    rf_data1 = 16'h0001;
    rf_data2 = 16'h0022;
    wb_reg_write = 1'b1;
    wb_write_op2 = 1'b1;
    wb_rd1 = 1;
    wb_rd2 = 2;
    wb_data1 = 16'hABCD;
    wb_data2 = 16'h5555;
    tick;
    check("byp_a_rd1", ex_a, 16'hABCD);
    check("byp_b_rd2", ex_b, 16'h5555);
    check("byp_fwd_a", fwd_a, 0);
    instr(OP_ADD, 3, 0, 13, 0, 1, 0, 1, 0, 0, 0);
    rf_data1 = 16'h0000;
    wb_rd1 = 3;
    wb_rd2 = 3;
    wb_data1 = 16'h1111;
    wb_data2 = 16'h2222;
    tick;
    check("byp_rd2_prio", ex_a, 16'h2222);
    instr(OP_ADD, 3, 0, 14, 0, 1, 0, 1, 0, 0, 0);
    wb_write_op2 = 1'b0;
    tick;
    check("byp_rd1_only", ex_a, 16'h1111);
    wb_reg_write = 1'b0;
    instr(OP_LOAD, 1, 0, 5, 0, 1, 0, 1, 0, 1, 0);
    tick;
    instr(OP_STORE, 5, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    #1 check("fl_pre_stall", stall, 1);
    flush = 1'b1;
    #1 check("fl_stall", stall, 0);
    tick;
    check("fl_valid", ex_valid, 0);
    check("fl_mem_write", ex_mem_write, 0);
    check("fl_fwd_a", fwd_a, 0);
    flush = 1'b0;
    instr(OP_ADD, 1, 0, 6, 0, 1, 0, 1, 0, 0, 0);
    tick;
    instr(OP_ADD, 6, 0, 7, 0, 1, 0, 1, 0, 0, 0);
    rst = 1'b1;
    tick;
    check("mrst_valid", ex_valid, 0);
    check("mrst_fwd_a", fwd_a, 0);
    rst = 1'b0;
    tick;
    check("post_rst_valid", ex_valid, 1);
    check("post_rst_fwd_a", fwd_a, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
